// File: rtl/fetch_sequencer_pkg.sv
// Shared KGP-miniRISC definitions: instruction geometry, branch condition
// encodings, sequencer state encoding and the condition evaluator.
`timescale 1ns/1ps
package miniRISC_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int COND_W   = 3;

  // Encodings of the decoder's 'conditional' field; 110/111 act as none.
  localparam logic [COND_W-1:0] COND_NONE = 3'b000;
  localparam logic [COND_W-1:0] COND_LTZ  = 3'b001;
  localparam logic [COND_W-1:0] COND_Z    = 3'b010;
  localparam logic [COND_W-1:0] COND_NZ   = 3'b011;
  localparam logic [COND_W-1:0] COND_CY   = 3'b100;
  localparam logic [COND_W-1:0] COND_NCY  = 3'b101;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_e;

  // True when the branch condition selected by 'cond' is satisfied.
  function automatic logic cond_holds(input logic [COND_W-1:0]  cond,
                                      input logic [INSTR_W-1:0] rs,
                                      input logic               cy);
    logic hit;
    hit = 1'b0;
    case (cond)
      COND_LTZ: hit = rs[INSTR_W-1];
      COND_Z:   hit = (rs == '0);
      COND_NZ:  hit = (rs != '0);
      COND_CY:  hit = cy;
      COND_NCY: hit = ~cy;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/fetch_sequencer_branch_resolver.sv
// Purely combinational next-PC selection for the fetch sequencer.
// Target priority: register jump, PC-relative jump, taken branch, fall-through.
`timescale 1ns/1ps
module branch_resolver
  import miniRISC_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFS_W  = 16
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [OFS_W-1:0]   offset,
  input  logic               unconditional,
  input  logic [COND_W-1:0]  conditional,
  input  logic               adsel,
  input  logic [INSTR_W-1:0] rs_data,
  input  logic               carry,
  output logic [ADDR_W-1:0]  next_pc,
  output logic [ADDR_W-1:0]  pc_link
);

  logic [ADDR_W-1:0] ofs_sext;
  logic [ADDR_W-1:0] ofs_target;
  logic [ADDR_W-1:0] reg_target;
  logic              taken;

  // Word offset is sign-extended to a byte offset; all sums wrap silently.
  assign ofs_sext   = {{(ADDR_W-OFS_W){offset[OFS_W-1]}}, offset};
  assign pc_link    = pc + ADDR_W'(4);
  assign ofs_target = pc_link + {ofs_sext[ADDR_W-3:0], 2'b00};
  assign reg_target = {rs_data[ADDR_W-1:2], 2'b00};
  assign taken      = cond_holds(conditional, rs_data, carry);

  // Pick the next PC from the decoder controls.
  always_comb begin
    next_pc = pc_link;
    if (unconditional && adsel) begin
      next_pc = reg_target;
    end else if (unconditional || taken) begin
      next_pc = ofs_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// KGP-miniRISC fetch/sequencing unit: owns the PC, fetches one word per
// instruction over a req/valid handshake, holds it for the datapath until
// ex_done, then advances the PC or stops on halt.
`timescale 1ns/1ps
module fetch_sequencer
  import miniRISC_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                OFS_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  input  logic                ex_done,
  input  logic                unconditional,
  input  logic [COND_W-1:0]   conditional,
  input  logic                adsel,
  input  logic                halt,
  input  logic [INSTR_W-1:0]  rs_data,
  input  logic                carry,
  output logic [ADDR_W-1:0]   pc_link,
  output logic                halted
);

  seq_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic               halted_q;

  branch_resolver #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_branch_resolver (
    .pc            (pc_q),
    .offset        (instr_q[OFS_W-1:0]),
    .unconditional (unconditional),
    .conditional   (conditional),
    .adsel         (adsel),
    .rs_data       (rs_data),
    .carry         (carry),
    .next_pc       (pc_d),
    .pc_link       (pc_link)
  );

  // Sequencer FSM; decoder controls are only trusted on the ex_done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ex_done) begin
            instr_valid_q <= 1'b0;
            if (halt) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALTED;
            end else begin
              pc_q    <= pc_d;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Request spans FETCH and WAIT; held low while reset is asserted so an
  // abandoned fetch is withdrawn immediately.
  assign imem_req    = reset & ((state_q == ST_FETCH) | (state_q == ST_WAIT));
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer with a behavioural
// next-PC reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        ex_done;
  logic        unconditional;
  logic [2:0]  conditional;
  logic        adsel;
  logic        halt;
  logic [31:0] rs_data;
  logic        carry;
  logic [31:0] pc_link;
  logic        halted;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;
  logic [31:0] frozen_pc;

  fetch_sequencer #(
    .ADDR_W   (32),
    .OFS_W    (16),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .ex_done       (ex_done),
    .unconditional (unconditional),
    .conditional   (conditional),
    .adsel         (adsel),
    .halt          (halt),
    .rs_data       (rs_data),
    .carry         (carry),
    .pc_link       (pc_link),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next PC computed from the architectural rules with plain arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [15:0] ofs,
                                              input logic unc, input logic [2:0] cond,
                                              input logic ads, input logic [31:0] rs,
                                              input logic cy);
    int  delta;
    bit  taken;
    delta = int'($signed(ofs)) * 4;
    case (cond)
      3'd1:    taken = rs[31];
      3'd2:    taken = (rs == 0);
      3'd3:    taken = (rs != 0);
      3'd4:    taken = cy;
      3'd5:    taken = !cy;
      default: taken = 0;
    endcase
    if (unc && ads) return rs & 32'hFFFF_FFFC;
    if (unc || taken) return pc + 32'd4 + 32'(delta);
    return pc + 32'd4;
  endfunction

  // Waits (bounded) for a request; expected to be entered on a negedge.
  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // One full instruction: fetch with 'lat' extra wait cycles, issue, then
  // ex_done after 'exlat' cycles with the given decoder controls.
  task automatic do_instr(input logic [31:0] word, input int lat,
                          input logic unc, input logic [2:0] cond, input logic ads,
                          input logic hlt, input logic [31:0] rs, input logic cy,
                          input int exlat);
    logic [31:0] exp_next;
    wait_req();
    check("imem_addr", imem_addr, model_pc);
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      check("req_held", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    check("instr_valid_on", {31'd0, instr_valid}, 32'd1);
    check("req_dropped", {31'd0, imem_req}, 32'd0);
    check("instr", instr, word);
    check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("pc_link", pc_link, model_pc + 32'd4);
    for (int i = 0; i < exlat; i++) begin
      // Decoder noise before ex_done must not matter.
      unconditional = 1'($urandom); halt = 1'($urandom); rs_data = $urandom;
      @(negedge clk);
      check("instr_valid_hold", {31'd0, instr_valid}, 32'd1);
    end
    unconditional = unc; conditional = cond; adsel = ads; halt = hlt;
    rs_data = rs; carry = cy; ex_done = 1'b1;
    exp_next = hlt ? model_pc : ref_next_pc(model_pc, word[15:0], unc, cond, ads, rs, cy);
    @(negedge clk);
    ex_done = 1'b0; halt = 1'b0; unconditional = 1'b0; conditional = 3'd0; adsel = 1'b0;
    check("instr_valid_off", {31'd0, instr_valid}, 32'd0);
    check("halted", {31'd0, halted}, {31'd0, hlt});
    check("next_addr", imem_addr, exp_next);
    $display("txn pc=%h word=%h unc=%0d cond=%0d adsel=%0d halt=%0d rs=%h cy=%0d -> %h",
             model_pc, word, unc, cond, ads, hlt, rs, cy, exp_next);
    model_pc = exp_next;
  endtask

  localparam logic [5:0] OP_ADDI = 6'b000001;

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0; ex_done = 1'b0;
    unconditional = 1'b0; conditional = 3'd0; adsel = 1'b0; halt = 1'b0;
    rs_data = '0; carry = 1'b0;
    model_pc = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);

    // Straight-line addi sequence: 0,4,8,0xC
    for (int k = 0; k < 4; k++)
      do_instr({OP_ADDI, 26'h0012345 + 26'(k)}, 0, 0, 3'd0, 0, 0, 32'd7, 0, 0);
    check("pc_at_10", model_pc, 32'h10);
    // b L with offset -2 at 0x10 -> 0x0C
    do_instr({6'b010000, 10'd0, 16'hFFFE}, 0, 1, 3'd0, 0, 0, 32'd0, 0, 0);
    check("b_target", imem_addr, 32'h0C);
    // bz not taken (rs=5) then taken (rs=0)
    do_instr({6'b010010, 10'd0, 16'h0004}, 1, 0, 3'b010, 0, 0, 32'd5, 0, 0);
    do_instr({6'b010010, 10'd0, 16'h0004}, 0, 0, 3'b010, 0, 0, 32'd0, 0, 2);
    check("bz_taken", imem_addr, 32'h24);
    // br rs=0x123 -> 0x120
    do_instr({6'b010001, 26'd0}, 0, 1, 3'd0, 1, 0, 32'h123, 0, 0);
    check("br_target", imem_addr, 32'h120);
    // br to 0x40, then bl at 0x40 (pc_link checked as 0x44 inside)
    do_instr({6'b010001, 26'd0}, 0, 1, 3'd0, 1, 0, 32'h40, 0, 0);
    do_instr({6'b010011, 10'd0, 16'h0010}, 0, 1, 3'd0, 0, 0, 32'd0, 0, 1);
    check("bl_target", imem_addr, 32'h84);

    // Randomized instructions against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_instr($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), 1'($urandom), 1'b0, rs, 1'($urandom),
               $urandom_range(0, 2));
    end

    // Halt: pc frozen, nothing requested, pulses ignored
    do_instr({6'b111111, 26'd0}, 0, 0, 3'd0, 0, 1, 32'd0, 0, 0);
    frozen_pc = model_pc;
    for (int k = 0; k < 20; k++) begin
      imem_valid = 1'($urandom); ex_done = 1'($urandom);
      unconditional = 1'($urandom); rs_data = $urandom;
      @(negedge clk);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_iv", {31'd0, instr_valid}, 32'd0);
      check("halt_pc", imem_addr, frozen_pc);
    end
    imem_valid = 1'b0; ex_done = 1'b0; unconditional = 1'b0;

    // Reset exits halt; then reset again mid-WAIT
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 32'h0;
    #1;
    check("post_halt_addr", imem_addr, 32'h0);
    check("post_halt_halted", {31'd0, halted}, 32'd0);
    do_instr({OP_ADDI, 26'd1}, 0, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    @(negedge clk);
    check("in_wait_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'd0, imem_req}, 32'd0);
    check("abort_iv", {31'd0, instr_valid}, 32'd0);
    check("abort_addr", imem_addr, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_valid = 1'b0;
    rst_n = 1'b1;
    model_pc = 32'h0;
    #1;
    check("refetch_req", {31'd0, imem_req}, 32'd1);
    repeat (2) @(negedge clk);
    check("stale_iv", {31'd0, instr_valid}, 32'd0);
    check("stale_instr", instr, 32'd0);
    do_instr({OP_ADDI, 26'h2}, 0, 0, 3'd0, 0, 0, 32'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
